// File: rtl/alu_mdu_pkg.sv
// Shared opcode constants for the EX-stage ALU and the multiply/divide unit.
// Pure definitions: no logic, no timing.
package alu_mdu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SRL  = 4'd4;
    localparam logic [3:0] ALU_SRA  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_NOR  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

endpackage

// File: rtl/alu_mdu_mdu_core.sv
// Multiply/divide unit owning HI/LO: latches operands on start, commits after MUL/DIV_CYCLES.
// Latency MUL_CYCLES/DIV_CYCLES (mthi/mtlo: 1 edge); start while busy is dropped, not queued.
module mdu_core #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    import alu_mdu_pkg::*;

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] LAST    = CW'(1);

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;

    // Datapath works only from the latched operands, so input changes during busy are invisible.
    logic                 mul_signed, div_signed, a_neg, b_neg, div_zero;
    logic [2*WIDTH-1:0]   a_ext, b_ext, prod;
    logic [WIDTH-1:0]     a_mag, b_mag, q_mag, r_mag, quot, rem;
    logic [WIDTH-1:0]     res_hi, res_lo;

    assign mul_signed = (op_q == MDU_MULT);
    assign div_signed = (op_q == MDU_DIV);
    assign a_ext      = {{WIDTH{mul_signed & a_q[WIDTH-1]}}, a_q};
    assign b_ext      = {{WIDTH{mul_signed & b_q[WIDTH-1]}}, b_q};
    assign prod       = a_ext * b_ext;

    assign a_neg    = div_signed & a_q[WIDTH-1];
    assign b_neg    = div_signed & b_q[WIDTH-1];
    assign div_zero = (b_q == '0);
    assign a_mag    = a_neg ? (~a_q + 1'b1) : a_q;
    assign b_mag    = b_neg ? (~b_q + 1'b1) : b_q;
    assign q_mag    = a_mag / b_mag;
    assign r_mag    = a_mag % b_mag;
    // MIN / -1 needs no special case: |MIN| / 1 re-wraps to MIN with a zero remainder.
    assign quot     = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    assign rem      = a_neg ? (~r_mag + 1'b1) : r_mag;

    always_comb begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if ((op_q == MDU_DIV) || (op_q == MDU_DIVU)) begin
            if (div_zero) begin
                res_hi = a_q;
                res_lo = '1;
            end else begin
                res_hi = rem;
                res_lo = quot;
            end
        end
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (busy_q) begin
            if (cnt_q == LAST) begin
                hi_d   = res_hi;
                lo_d   = res_lo;
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (start_i) begin
            case (op_i)
                MDU_MULT, MDU_MULTU: begin
                    a_d    = a_i;
                    b_d    = b_i;
                    op_d   = op_i;
                    cnt_d  = MUL_CNT;
                    busy_d = 1'b1;
                end
                MDU_DIV, MDU_DIVU: begin
                    a_d    = a_i;
                    b_d    = b_i;
                    op_d   = op_i;
                    cnt_d  = DIV_CNT;
                    busy_d = 1'b1;
                end
                MDU_MTHI: hi_d = a_i;
                MDU_MTLO: lo_d = a_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign busy_o = busy_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: rtl/alu_mdu.sv
// EX-stage execution unit: combinational ALU plus the sequential multiply/divide core.
// ALU has zero latency; MDU stalls the pipe through busy and ignores start while busy.
module alu_mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOp,
    output logic [WIDTH-1:0] C,
    input  logic             start,
    input  logic [2:0]       MDUOp,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import alu_mdu_pkg::*;

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] alu_res;

    // Only the low log2(WIDTH) bits of B select the shift distance.
    assign sh = B[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (ALUOp)
            ALU_ADD:  alu_res = A + B;
            ALU_SUB:  alu_res = A - B;
            ALU_AND:  alu_res = A & B;
            ALU_OR:   alu_res = A | B;
            ALU_SRL:  alu_res = A >> sh;
            ALU_SRA:  alu_res = $signed(A) >>> sh;
            ALU_SLL:  alu_res = A << sh;
            ALU_XOR:  alu_res = A ^ B;
            ALU_NOR:  alu_res = ~(A | B);
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            ALU_LUI:  alu_res = B << (WIDTH / 2);
            default:  alu_res = '0;
        endcase
    end

    assign C = alu_res;

    mdu_core #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_mdu_core (
        .clk     (clk),
        .reset   (reset),
        .a_i     (A),
        .b_i     (B),
        .start_i (start),
        .op_i    (MDUOp),
        .busy_o  (busy),
        .hi_o    (hi),
        .lo_o    (lo)
    );

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised datapath execution unit for the CPU EX stage.
- Combines a single-cycle integer ALU (widened op set) with a multi-cycle multiply/divide unit (MDU) that owns HI/LO registers.
- The MDU has a start/busy handshake. The pipeline stalls on busy and reads HI/LO through `hi`/`lo`.
- Successor to the 3-bit-op combinational ALU. It adds compare, xor/nor and left-shift ops, width parametrisation, and sequential mul/div.

Parameters:
- WIDTH, 32, datapath width in bits (≥8, power of 2).
- MUL_CYCLES, 5, busy duration of mult/multu in cycles (≥1).
- DIV_CYCLES, 10, busy duration of div/divu in cycles (≥1).

Ports:
- clk  input  1  clock, all state rises on posedge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- A  input  WIDTH  operand A (rs).
- B  input  WIDTH  operand B (rt / immediate).
- ALUOp  input  4  ALU operation select.
- C  output  WIDTH  ALU result, combinational.
- start  input  1  MDU command strobe, one cycle.
- MDUOp  input  3  MDU command, sampled with start.
- busy  output  1  MDU operation in progress (registered).
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- ALU (combinational, no state); sh = B[log2(WIDTH)-1:0]:
  - 0 add A+B (wraps, no overflow flag); 1 sub A-B; 2 and; 3 or; 4 srl A>>sh; 5 sra signed(A)>>>sh.
  - 6 sll A<<sh; 7 xor; 8 nor; 9 slt (signed A<B ? 1 : 0, zero-extended); 10 sltu (unsigned).
  - 11 lui B<<(WIDTH/2); 12–15 → C=0.
- MDUOp encoding: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6–7 no-op.
- Reset (reset==0 at posedge): hi=0, lo=0, busy=0, counter=0, pending op discarded, including mid-operation.
- start accepted only when busy==0 and reset==1. start while busy=1 is ignored: no state change, no queuing.
- mult/multu:
  - At the accepting edge, latch A, B and op; load counter=MUL_CYCLES; busy=1 from the next cycle.
  - busy stays high exactly MUL_CYCLES cycles.
  - At the edge that ends the last busy cycle: {hi,lo} = full 2*WIDTH product (signed/unsigned per op); busy falls at the same edge.
- div/divu: same sequence with DIV_CYCLES. lo = quotient, hi = remainder.
  - Signed division truncates toward zero; remainder takes the dividend's sign.
- Divide by zero: lo = all ones, hi = latched A (both signed and unsigned). Signed overflow (MIN / -1): lo = MIN, hi = 0.
- mthi/mtlo (busy==0): hi (resp. lo) = A at the accepting edge; busy stays 0. Single cycle.
- hi/lo hold previous values throughout a busy period; visible only after commit.
- Operand changes on A/B during busy have no effect (operands latched).
- No-op MDUOp with start: nothing happens, busy stays 0.
- Back-to-back: start may be accepted in the first cycle busy==0 after commit.
- Arithmetic is computed once from the latched operands; the counter only models latency. Result is held internally and committed at count end.

Decomposition:
- Shared package: ALUOp constants (ALU_ADD…ALU_LUI), MDUOp constants (MDU_MULT…MDU_MTLO).
- One sub-module: mdu_core. It owns the counter, operand latches, hi/lo and busy, and computes product/quotient.
- alu_mdu instantiates mdu_core and implements the combinational ALU case.

Test Plan:
- ALU sweep at WIDTH=32:
  - A=0xFFFFFFFF, B=1: add→0, sltu→0, slt→1.
  - A=0x80000000, B=4: sra→0xF8000000, srl→0x08000000.
  - A=1, B=33: sll→2 (shift uses 5 LSBs).
- multu:
  - start with A=0xFFFFFFFF, B=2 → busy high exactly 5 cycles, hi/lo unchanged until the commit edge.
  - After commit: hi=0x00000001, lo=0xFFFFFFFE.
  - Signed mult of the same operands → hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- div with A=-7, B=2 → after 10 busy cycles: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Boundary division cases:
  - divu with B=0, A=0x1234 → lo=0xFFFFFFFF, hi=0x1234.
  - div with A=0x80000000, B=-1 → lo=0x80000000, hi=0.
- Ignored start during busy:
  - start mult mid-busy and change A/B → ignored; original result committed.
  - mthi with A=0xAA the cycle after busy falls → hi=0xAA, busy stays 0.
- Reset mid-operation:
  - Assert reset=0 in busy cycle 3 of div → next edge busy=0, hi=lo=0, no later commit.
  - Rerun the multu case with WIDTH=16 → hi/lo split at bit 16.
